fx_bus_master: RTL and testbench
================================

Name: fx_bus_master

Overview:
- Initiator side of the fx register bus; drives the bus that all per-device register slaves decode.
- Accepts a host byte-stream command packet (from USB/UART front end) and issues fx_wr / fx_rd cycles.
- Read-back bytes are returned on a response byte stream, buffered in a small FIFO with backpressure.

Parameters:
- RD_FIFO_DEPTH, 4, response FIFO depth in bytes (power of two, 2..16).

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_data  in  8  command stream byte
- cmd_vld  in  1  cmd_data valid
- cmd_rdy  out  1  byte accepted when cmd_vld & cmd_rdy at rising edge
- rsp_data  out  8  read-back byte (FIFO head)
- rsp_vld  out  1  FIFO not empty
- rsp_rdy  in  1  pop when rsp_vld & rsp_rdy
- fx_waddr  out  22  write address, [21:16] device id, [15:0] register
- fx_wr  out  1  one-cycle write strobe
- fx_data  out  8  write data
- fx_raddr  out  22  read address
- fx_rd  out  1  one-cycle read strobe
- fx_q  in  8  slave read data, valid the cycle after fx_rd
- busy  out  1  state != IDLE or reads in flight
- stu_err_cnt  out  8  bad-opcode count, saturates at 0xFF

Behaviour:
- Packet: OP, A2 (addr[21:16], upper 2 bits ignored), A1 (addr[15:8]), A0 (addr[7:0]), LEN, then LEN data bytes for writes only. OP 0x01 = write, 0x02 = read. LEN 0 means 256; the remaining count is 9 bits.
- Reset: all outputs 0, FIFO empty, state IDLE, stu_err_cnt 0. Reset mid-packet abandons the packet, discards in-flight reads and flushes the FIFO.
- States and transitions:
  - IDLE: cmd_rdy=1. OP 0x01 or 0x02 goes to ADR2. Any other OP stays in IDLE and increments stu_err_cnt (saturating).
  - ADR2, ADR1, ADR0, LEN: cmd_rdy=1; one byte is accepted per state.
  - LEN goes to WDAT for a write, or RDIS for a read.
  - WDAT: cmd_rdy=1.
    - Each accepted byte gives, on the next cycle, fx_wr=1, fx_data=byte, fx_waddr=current address; then the address increments.
    - Back-to-back accepted bytes produce back-to-back fx_wr cycles.
    - After LEN bytes, go to IDLE.
  - RDIS: cmd_rdy=0.
    - fx_rd=1 with fx_raddr=current address is issued in a cycle only if (fifo_count + inflight) < RD_FIFO_DEPTH. The address then increments and the count decrements.
    - When the count reaches 0, go to IDLE; no wait for in-flight data.
- Address increment: only [15:0] increments, wrapping 0xFFFF -> 0x0000; [21:16] stays fixed for the whole packet.
- Outputs in idle: fx_wr and fx_rd are 0 except in issue cycles. fx_data, fx_waddr and fx_raddr hold their last values. fx_wr and fx_rd are never high in the same cycle.
- Read capture:
  - rd_d1 = fx_rd registered. The slave presents fx_q one cycle after sampling fx_rd.
  - fx_q is pushed into the FIFO at the rising edge that ends the cycle in which rd_d1=1. Read latency is 2 cycles from fx_rd high to FIFO push.
  - inflight counts 0..2.
- FIFO:
  - rsp_data = head and rsp_vld = !empty, both combinational from registered state.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow cannot occur because of the issue gating.
  - FIFO order equals read issue order, across packets as well.
- New packets: a new packet may start while the FIFO still holds data or reads are in flight.
- busy: 1 in any state other than IDLE, or when inflight != 0. It ignores FIFO occupancy.

Test Plan:
- Write: packet 01 05 00 20 02 34 12 -> exactly two fx_wr pulses: fx_waddr 0x050020 with data 0x34, then 0x050021 with 0x12; cmd_rdy stays 1 throughout; busy returns to 0.
- Read: slave model where cfg_th=0x7800 at 0x20/0x21, rsp_rdy=1, packet 02 05 00 20 02 -> fx_rd at 0x050020 then 0x050021; rsp bytes 0x00, 0x78; each byte appears 2 cycles after its fx_rd.
- Backpressure: rsp_rdy=0, read LEN=8 -> exactly 4 fx_rd issued and then stalled, rsp_vld=1. Release rsp_rdy -> remaining 4 issued; all 8 bytes arrive in address order with no loss or duplicate.
- Wrap and LEN=0:
  - Write LEN 2 at 0x03FFFF -> writes go to 0x03FFFF then 0x030000.
  - Read with LEN 0x00 -> exactly 256 fx_rd.
- Bad opcode: byte 0x7F, then a valid write packet -> stu_err_cnt=1 and the write completes normally. 300 bad bytes -> stu_err_cnt=0xFF.
- Reset mid-packet: assert rst after 3 of 5 write data bytes -> no further fx_wr, FIFO empty, state IDLE; the next full packet executes correctly.

Source files
------------

// File: rtl/fx_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fx_bus_master
// Purpose  : Turns host command packets into fx register bus write and read
//            cycles, and returns read data through a response FIFO.
// Revision : 1.0  initial release
// ============================================================================
module fx_bus_master #(
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    output logic [7:0]  rsp_data,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [21:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic [7:0]  stu_err_cnt
);

    localparam int c_PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(RD_FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ADR2 = 3'd1;
    localparam logic [2:0] c_ST_ADR1 = 3'd2;
    localparam logic [2:0] c_ST_ADR0 = 3'd3;
    localparam logic [2:0] c_ST_LEN  = 3'd4;
    localparam logic [2:0] c_ST_WDAT = 3'd5;
    localparam logic [2:0] c_ST_RDIS = 3'd6;

    logic [2:0]       r_state;
    logic             r_is_rd;
    logic [5:0]       r_dev;
    logic [15:0]      r_reg;
    logic [8:0]       r_cnt;
    logic [21:0]      r_fx_waddr;
    logic             r_fx_wr;
    logic [7:0]       r_fx_data;
    logic [21:0]      r_fx_raddr;
    logic             r_fx_rd;
    logic             r_rd_d1;
    logic [7:0]       r_err_cnt;
    logic [7:0]       r_mem [RD_FIFO_DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_fcnt;

    logic             w_cmd_rdy;
    logic             w_acc;
    logic [1:0]       w_inflight;
    logic             w_room;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    assign w_cmd_rdy  = (r_state != c_ST_RDIS);
    assign w_acc      = cmd_vld & w_cmd_rdy;
    // A read is outstanding while its strobe or its delayed copy is high.
    assign w_inflight = {1'b0, r_fx_rd} + {1'b0, r_rd_d1};
    assign w_room     = ({1'b0, r_fcnt} + (c_CW + 1)'(w_inflight)) < c_DEPTH;
    assign w_issue    = (r_state == c_ST_RDIS) && w_room;
    assign w_push     = r_rd_d1;
    assign w_pop      = (r_fcnt != '0) && rsp_rdy;

    assign cmd_rdy     = w_cmd_rdy;
    assign rsp_data    = r_mem[r_rptr];
    assign rsp_vld     = (r_fcnt != '0);
    assign fx_waddr    = r_fx_waddr;
    assign fx_wr       = r_fx_wr;
    assign fx_data     = r_fx_data;
    assign fx_raddr    = r_fx_raddr;
    assign fx_rd       = r_fx_rd;
    assign busy        = (r_state != c_ST_IDLE) || (w_inflight != 2'd0);
    assign stu_err_cnt = r_err_cnt;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_is_rd    <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_cnt      <= '0;
            r_fx_waddr <= '0;
            r_fx_wr    <= 1'b0;
            r_fx_data  <= '0;
            r_fx_raddr <= '0;
            r_fx_rd    <= 1'b0;
            r_rd_d1    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_fx_wr <= 1'b0;
            r_fx_rd <= 1'b0;
            r_rd_d1 <= r_fx_rd;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_acc) begin
                        if (cmd_data == 8'h01 || cmd_data == 8'h02) begin
                            r_is_rd <= (cmd_data == 8'h02);
                            r_state <= c_ST_ADR2;
                        end else if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                c_ST_ADR2: if (w_acc) begin
                    r_dev   <= cmd_data[5:0];
                    r_state <= c_ST_ADR1;
                end
                c_ST_ADR1: if (w_acc) begin
                    r_reg[15:8] <= cmd_data;
                    r_state     <= c_ST_ADR0;
                end
                c_ST_ADR0: if (w_acc) begin
                    r_reg[7:0] <= cmd_data;
                    r_state    <= c_ST_LEN;
                end
                c_ST_LEN: if (w_acc) begin
                    r_cnt   <= (cmd_data == 8'h00) ? 9'd256 : {1'b0, cmd_data};
                    r_state <= r_is_rd ? c_ST_RDIS : c_ST_WDAT;
                end
                c_ST_WDAT: if (w_acc) begin
                    r_fx_wr    <= 1'b1;
                    r_fx_data  <= cmd_data;
                    r_fx_waddr <= {r_dev, r_reg};
                    r_reg      <= r_reg + 16'd1;
                    r_cnt      <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) r_state <= c_ST_IDLE;
                end
                c_ST_RDIS: if (w_issue) begin
                    r_fx_rd    <= 1'b1;
                    r_fx_raddr <= {r_dev, r_reg};
                    r_reg      <= r_reg + 16'd1;
                    r_cnt      <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // fx_q is valid in the cycle where the delayed read strobe is high.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < RD_FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= fx_q;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fx_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fx_bus_master
// Purpose  : Directed scoreboard bench for fx_bus_master with a slave model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fx_bus_master;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [7:0]  cmd_data;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [7:0]  rsp_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q = 8'h00;
    logic        busy;
    logic [7:0]  stu_err_cnt;

    always #5 clk_sys = ~clk_sys;

    fx_bus_master #(.RD_FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .cmd_data(cmd_data), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
        .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
        .busy(busy), .stu_err_cnt(stu_err_cnt)
    );

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_rd = 0;
    int stalls = 0;
    bit chk_lat = 1'b0;

    logic [29:0] exp_w[$];
    logic [21:0] exp_ra[$];
    logic [7:0]  exp_rsp[$];
    int          rd_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave register contents: cfg_th = 0x7800 at 0x050020/0x050021.
    function automatic logic [7:0] slv(input logic [21:0] a);
        if (a == 22'h050020) return 8'h00;
        if (a == 22'h050021) return 8'h78;
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    always @(posedge clk_sys) cyc <= cyc + 1;
    always @(posedge clk_sys) if (fx_rd) fx_q <= slv(fx_raddr);

    always @(negedge clk_sys) begin
        int c;
        if (fx_wr) begin
            n_wr++;
            chk("wr_rd_exclusive", {31'd0, fx_rd}, 32'd0);
            chk("wr_expected", {31'd0, exp_w.size() != 0}, 32'd1);
            if (exp_w.size() != 0) chk("wr_addr_data", {2'b00, fx_waddr, fx_data}, {2'b00, exp_w.pop_front()});
        end
        if (fx_rd) begin
            n_rd++;
            rd_cyc.push_back(cyc);
            chk("rd_expected", {31'd0, exp_ra.size() != 0}, 32'd1);
            if (exp_ra.size() != 0) chk("rd_addr", {10'd0, fx_raddr}, {10'd0, exp_ra.pop_front()});
        end
        if (rsp_vld && rsp_rdy && !rst) begin
            chk("rsp_expected", {31'd0, exp_rsp.size() != 0}, 32'd1);
            if (exp_rsp.size() != 0) chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
            if (rd_cyc.size() != 0) begin
                c = rd_cyc.pop_front();
                if (chk_lat) chk("rsp_latency", cyc, c + 2);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w = 0;
        cmd_data = b;
        cmd_vld  = 1'b1;
        @(negedge clk_sys);
        while (!cmd_rdy && w < 5000) begin
            w++;
            @(negedge clk_sys);
        end
        stalls += w;
        if (w >= 5000) chk("cmd_rdy_timeout", w, 0);
        @(posedge clk_sys);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wr_pkt(input logic [7:0] a2, input logic [15:0] a, input logic [7:0] d[$]);
        for (int i = 0; i < d.size(); i++) exp_w.push_back({a2[5:0], a + 16'(i), d[i]});
        send(8'h01); send(a2); send(a[15:8]); send(a[7:0]); send(8'(d.size()));
        for (int i = 0; i < d.size(); i++) send(d[i]);
    endtask

    task automatic rd_pkt(input logic [7:0] a2, input logic [15:0] a, input logic [7:0] lenb, input bit push_rsp);
        int n;
        logic [21:0] ad;
        n = (lenb == 8'h00) ? 256 : int'(lenb);
        for (int i = 0; i < n; i++) begin
            ad = {a2[5:0], a + 16'(i)};
            exp_ra.push_back(ad);
            if (push_rsp) exp_rsp.push_back(slv(ad));
        end
        send(8'h02); send(a2); send(a[15:8]); send(a[7:0]); send(lenb);
    endtask

    task automatic idle_wait(input string tag);
        int w = 0;
        while ((busy || exp_w.size() != 0 || exp_ra.size() != 0 || exp_rsp.size() != 0) && w < 5000) begin
            w++;
            @(negedge clk_sys);
        end
        chk(tag, {31'd0, w < 5000}, 32'd1);
        repeat (2) @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[$];
        int n0;
        int s0;
        int w;
        rst = 1'b1; cmd_vld = 1'b0; cmd_data = 8'h00; rsp_rdy = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;
        @(negedge clk_sys);
        chk("rst_fx_wr", {31'd0, fx_wr}, 32'd0);
        chk("rst_fx_rd", {31'd0, fx_rd}, 32'd0);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_cnt", {24'd0, stu_err_cnt}, 32'd0);
        chk("rst_addrs", {2'b00, fx_waddr, fx_data}, {2'b00, fx_raddr, 8'h00});
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        @(posedge clk_sys); #1;

        // Plain write
        n0 = n_wr; s0 = stalls;
        d = '{8'h34, 8'h12};
        wr_pkt(8'h05, 16'h0020, d);
        idle_wait("wr_done");
        chk("wr_count", n_wr - n0, 2);
        chk("wr_no_stall", stalls - s0, 0);
        chk("wr_busy_idle", {31'd0, busy}, 32'd0);

        // Read with latency check
        rsp_rdy = 1'b1; chk_lat = 1'b1;
        n0 = n_rd;
        rd_pkt(8'h05, 16'h0020, 8'h02, 1'b1);
        idle_wait("rd_done");
        chk("rd_count", n_rd - n0, 2);
        chk_lat = 1'b0;

        // Backpressure stalls issue at FIFO depth
        rsp_rdy = 1'b0;
        n0 = n_rd;
        rd_pkt(8'h0A, 16'h0100, 8'h08, 1'b1);
        repeat (20) @(negedge clk_sys);
        chk("bp_issued", n_rd - n0, 4);
        chk("bp_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        @(posedge clk_sys); #1;
        rsp_rdy = 1'b1;
        idle_wait("bp_done");
        chk("bp_total", n_rd - n0, 8);

        // Register address wrap, upper A2 bits ignored
        n0 = n_wr;
        d = '{8'hAA, 8'hBB};
        wr_pkt(8'hC3, 16'hFFFF, d);
        idle_wait("wrap_done");
        chk("wrap_count", n_wr - n0, 2);

        // LEN 0 means 256
        n0 = n_rd;
        rd_pkt(8'h01, 16'h1234, 8'h00, 1'b1);
        idle_wait("len0_done");
        chk("len0_count", n_rd - n0, 256);

        // Bad opcodes
        send(8'h7F);
        chk("err_one", {24'd0, stu_err_cnt}, 32'd1);
        n0 = n_wr;
        d = '{8'h5C};
        wr_pkt(8'h02, 16'h0010, d);
        idle_wait("err_wr_done");
        chk("err_after_wr", {24'd0, stu_err_cnt}, 32'd1);
        chk("err_wr_count", n_wr - n0, 1);
        for (int i = 0; i < 300; i++) send(8'((i % 250) + 3));
        chk("err_sat", {24'd0, stu_err_cnt}, 32'hFF);

        // Reset mid-packet with FIFO holding data
        rsp_rdy = 1'b0;
        rd_pkt(8'h06, 16'h0000, 8'h03, 1'b0);
        w = 0;
        while (exp_ra.size() != 0 && w < 200) begin w++; @(negedge clk_sys); end
        repeat (4) @(negedge clk_sys);
        chk("pre_rst_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        @(posedge clk_sys); #1;
        n0 = n_wr;
        exp_w.push_back({6'h04, 16'h0040, 8'h11});
        exp_w.push_back({6'h04, 16'h0041, 8'h22});
        exp_w.push_back({6'h04, 16'h0042, 8'h33});
        send(8'h01); send(8'h04); send(8'h00); send(8'h40); send(8'h05);
        send(8'h11); send(8'h22); send(8'h33);
        rst = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 rst = 1'b0;
        rd_cyc.delete();
        repeat (5) @(negedge clk_sys);
        chk("mid_rst_wr_count", n_wr - n0, 3);
        chk("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("mid_rst_err", {24'd0, stu_err_cnt}, 32'd0);
        @(posedge clk_sys); #1;
        n0 = n_wr;
        d = '{8'h77};
        wr_pkt(8'h04, 16'h0050, d);
        rsp_rdy = 1'b1;
        rd_pkt(8'h04, 16'h0050, 8'h01, 1'b1);
        idle_wait("post_rst_done");
        chk("post_rst_wr_count", n_wr - n0, 1);

        chk("end_exp_w", exp_w.size(), 0);
        chk("end_exp_ra", exp_ra.size(), 0);
        chk("end_exp_rsp", exp_rsp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
